playfield_arbiter: RTL and testbench



---
 rtl/playfield_pkg.sv | 31 +++
 rtl/pf_clear_walker.sv | 36 +++
 rtl/playfield_arbiter.sv | 140 ++++++++++++++
 tb/tb_playfield_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/playfield_pkg.sv
// Shared playfield geometry, arbiter state encoding and colour indices.
// Pure declarations: no latency, no flow control.
package playfield_pkg;

    localparam int COLS  = 10;
    localparam int ROWS  = 20;
    localparam int CELLS = COLS * ROWS;
    localparam int AW    = 8;
    localparam int DW    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GL_WR = 2'd1,
        GL_RD = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam logic [DW-1:0] COL_EMPTY  = 3'd0;
    localparam logic [DW-1:0] COL_CYAN   = 3'd1;
    localparam logic [DW-1:0] COL_YELLOW = 3'd2;
    localparam logic [DW-1:0] COL_PURPLE = 3'd3;
    localparam logic [DW-1:0] COL_GREEN  = 3'd4;
    localparam logic [DW-1:0] COL_RED    = 3'd5;
    localparam logic [DW-1:0] COL_BLUE   = 3'd6;
    localparam logic [DW-1:0] COL_ORANGE = 3'd7;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return addr < AW'(CELLS);
    endfunction

endpackage

// File: rtl/pf_clear_walker.sv
// Clear address counter: steps 0..CELLS-1 once per enabled cycle, flags the last cell.
// Zero latency on the flag; advance is gated purely by en_i (renderer stalls it).
module pf_clear_walker
    import playfield_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          en_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [AW-1:0] addr_q, addr_d;

    assign addr_o = addr_q;
    assign last_o = (addr_q == AW'(CELLS - 1));

    always_comb begin
        addr_d = addr_q;
        if (start_i) begin
            addr_d = '0;
        end else if (en_i) begin
            addr_d = last_o ? '0 : addr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/playfield_arbiter.sv
// Single-port playfield RAM arbiter: renderer > clear walker > game. Renderer data at t+2,
// game write ack at t+1 / read ack at t+2 after grant; game waits while the renderer or a clear owns the port.
module playfield_arbiter
    import playfield_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    input  logic          gl_req,
    input  logic          gl_we,
    input  logic [AW-1:0] gl_addr,
    input  logic [DW-1:0] gl_wdata,
    output logic          gl_ack,
    output logic [DW-1:0] gl_rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    state_t        state_q, state_d;
    logic          rd_wait_q, rd_wait_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          vid_p1_q, vid_ok1_q, vid_valid_q, clr_done_q;
    logic [DW-1:0] vid_data_q;

    logic          vid_in, gl_in;
    logic          walk_start, walk_en, walk_last;
    logic [AW-1:0] walk_addr;

    assign vid_in    = in_range(vid_addr);
    assign gl_in     = in_range(gl_addr);
    assign walk_en   = (state_q == CLEAR) && !vid_req;
    assign clr_busy  = (state_q == CLEAR);
    assign clr_done  = clr_done_q;
    assign vid_valid = vid_valid_q;
    assign vid_data  = vid_data_q;

    pf_clear_walker u_walker (
        .clk     (clk),
        .rst     (rst),
        .start_i (walk_start),
        .en_i    (walk_en),
        .addr_o  (walk_addr),
        .last_o  (walk_last)
    );

    always_comb begin
        state_d    = state_q;
        rd_wait_d  = rd_wait_q;
        rdata_d    = rdata_q;
        walk_start = 1'b0;
        gl_ack     = 1'b0;
        gl_rdata   = '0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;

        // Port slot: renderer, then clear walker, then a fresh game request.
        if (vid_req) begin
            ram_en   = vid_in;
            ram_addr = vid_addr;
        end else if (state_q == CLEAR) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = walk_addr;
            ram_wdata = COL_EMPTY;
        end else if (state_q == IDLE && gl_req && !clr_start) begin
            ram_en    = gl_in;
            ram_we    = gl_we && gl_in;
            ram_addr  = gl_addr;
            ram_wdata = gl_wdata;
        end

        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d    = CLEAR;
                    walk_start = 1'b1;
                end else if (gl_req && !vid_req) begin
                    state_d   = gl_we ? GL_WR : GL_RD;
                    rd_wait_d = 1'b0;
                end
            end
            GL_WR: begin
                gl_ack  = 1'b1;
                state_d = IDLE;
            end
            GL_RD: begin
                // First cycle captures the RAM word; the second acks while gl_req is still held.
                if (!rd_wait_q) begin
                    rd_wait_d = 1'b1;
                    rdata_d   = gl_in ? ram_rdata : COL_EMPTY;
                end else begin
                    gl_ack    = 1'b1;
                    gl_rdata  = rdata_q;
                    rd_wait_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            CLEAR: begin
                if (walk_en && walk_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_wait_q   <= 1'b0;
            rdata_q     <= '0;
            vid_p1_q    <= 1'b0;
            vid_ok1_q   <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_wait_q   <= rd_wait_d;
            rdata_q     <= rdata_d;
            vid_p1_q    <= vid_req;
            vid_ok1_q   <= vid_req && vid_in;
            vid_valid_q <= vid_p1_q;
            vid_data_q  <= vid_ok1_q ? ram_rdata : COL_EMPTY;
            clr_done_q  <= walk_en && walk_last;
        end
    end

endmodule

// File: tb/tb_playfield_arbiter.sv
// Directed bench for playfield_arbiter with a behavioural synchronous RAM on the port.
module tb_playfield_arbiter;
    import playfield_pkg::*;

    logic          clk;
    logic          rst;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          gl_req;
    logic          gl_we;
    logic [AW-1:0] gl_addr;
    logic [DW-1:0] gl_wdata;
    logic          gl_ack;
    logic [DW-1:0] gl_rdata;
    logic          clr_start;
    logic          clr_busy;
    logic          clr_done;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [0:255];

    int n_checks;
    int n_pass;
    int lat;
    logic [DW-1:0] rd;
    int cyc, nwr, bad_wr, ndone, ack_early, nack, nz, quiet_bad;
    int exp_addr;
    logic en_seen, done_seen, got_ack, hit;

    playfield_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .gl_req    (gl_req),
        .gl_we     (gl_we),
        .gl_addr   (gl_addr),
        .gl_wdata  (gl_wdata),
        .gl_ack    (gl_ack),
        .gl_rdata  (gl_rdata),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous RAM
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic gl_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         output int l, output logic [DW-1:0] r);
        @(negedge clk);
        gl_req = 1'b1; gl_we = we; gl_addr = a; gl_wdata = wd;
        l = 0;
        #1;
        while (!gl_ack && l < 50) begin
            @(negedge clk);
            #1;
            l++;
        end
        r = gl_rdata;
        @(negedge clk);
        gl_req = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1; vid_req = 1'b0; vid_addr = '0; gl_req = 1'b0; gl_we = 1'b0;
        gl_addr = '0; gl_wdata = '0; clr_start = 1'b0; ram_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_outs", {vid_valid, vid_data, gl_ack, gl_rdata, clr_busy, clr_done,
                           ram_en, ram_we, ram_addr, ram_wdata}, 0);

        // Preload cells 5 and 6 through the game port
        gl_op(1'b1, 8'd5, 3'd3, lat, rd);
        chk("wr5_lat", lat, 1);
        gl_op(1'b1, 8'd6, 3'd7, lat, rd);
        chk("wr6_lat", lat, 1);

        // Back-to-back renderer reads
        @(negedge clk); vid_req = 1'b1; vid_addr = 8'd5; #1;
        chk("b2b_ram", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 8'd5});
        @(negedge clk); vid_addr = 8'd6;
        @(negedge clk); vid_req = 1'b0; #1;
        chk("b2b_first", {vid_valid, vid_data}, {1'b1, 3'd3});
        @(negedge clk); #1;
        chk("b2b_second", {vid_valid, vid_data}, {1'b1, 3'd7});
        @(negedge clk); #1;
        chk("b2b_idle", vid_valid, 0);

        // Game write stalled three cycles by the renderer
        @(negedge clk);
        gl_req = 1'b1; gl_we = 1'b1; gl_addr = 8'd12; gl_wdata = 3'd4;
        vid_req = 1'b1; vid_addr = 8'd0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("cont_hold", {ram_we, gl_ack}, 0);
        end
        @(negedge clk); vid_req = 1'b0; #1;
        chk("cont_grant", {ram_en, ram_we, ram_addr, ram_wdata}, {1'b1, 1'b1, 8'd12, 3'd4});
        @(negedge clk); #1;
        chk("cont_ack", gl_ack, 1);
        chk("cont_noregrant", ram_en, 0);
        @(negedge clk); gl_req = 1'b0; #1;
        chk("cont_ack_pulse", gl_ack, 0);
        gl_op(1'b0, 8'd12, 3'd0, lat, rd);
        chk("rd12_lat", lat, 2);
        chk("rd12_data", rd, 4);

        // Out-of-range game read: ram_rdata still holds 4 from the last read
        @(negedge clk);
        gl_req = 1'b1; gl_we = 1'b0; gl_addr = 8'd200; #1;
        en_seen = ram_en;
        @(negedge clk); #1;
        en_seen = en_seen | ram_en;
        chk("oor_early_ack", gl_ack, 0);
        @(negedge clk); #1;
        en_seen = en_seen | ram_en;
        chk("oor_ack", gl_ack, 1);
        chk("oor_rdata", gl_rdata, 0);
        @(negedge clk); gl_req = 1'b0;
        chk("oor_ram_en", en_seen, 0);

        // Out-of-range renderer read
        @(negedge clk); vid_req = 1'b1; vid_addr = 8'd255; #1;
        chk("vid_oor_en", ram_en, 0);
        @(negedge clk); vid_req = 1'b0;
        @(negedge clk); #1;
        chk("vid_oor_out", {vid_valid, vid_data}, {1'b1, 3'd0});

        // Clear and game write start together; renderer on every other cycle
        @(negedge clk);
        clr_start = 1'b1; gl_req = 1'b1; gl_we = 1'b1; gl_addr = 8'd7; gl_wdata = 3'd5; #1;
        chk("sim_nogrant", ram_en, 0);
        exp_addr = 0; nwr = 0; bad_wr = 0; ndone = 0; ack_early = 0; cyc = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 1000) begin
            @(negedge clk);
            clr_start = (cyc == 30);
            vid_req = (cyc % 2 == 0);
            vid_addr = 8'd5;
            #1;
            if (cyc == 0) chk("clr_busy", clr_busy, 1);
            if (clr_busy && ram_en && ram_we) begin
                if (ram_addr != exp_addr[AW-1:0] || ram_wdata != 0) bad_wr++;
                exp_addr++;
                nwr++;
            end
            if (gl_ack) ack_early++;
            if (clr_done) begin
                ndone++;
                done_seen = 1'b1;
                chk("done_busy_low", clr_busy, 0);
            end
            cyc++;
        end
        clr_start = 1'b0;
        chk("clr_done_seen", done_seen, 1);
        nack = 0; got_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            vid_req = 1'b0;
            if (got_ack) gl_req = 1'b0;
            #1;
            if (clr_done) ndone++;
            if (gl_ack) begin
                nack++;
                got_ack = 1'b1;
            end
        end
        chk("clr_writes", nwr, 200);
        chk("clr_order", bad_wr, 0);
        chk("clr_done_once", ndone, 1);
        chk("gl_ack_during_clr", ack_early, 0);
        chk("gl_ack_after_clr", nack, 1);
        nz = 0;
        for (int i = 0; i < CELLS; i++) if (i != 7 && mem[i] != 0) nz++;
        chk("clr_cells_zero", nz, 0);
        chk("cell7_written", mem[7], 5);

        // Reset in the middle of a clear
        @(negedge clk); clr_start = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(negedge clk);
            clr_start = 1'b0;
            #1;
            if (clr_busy && ram_we && ram_addr == 8'd80) hit = 1'b1;
        end
        chk("walker_at_80", hit, 1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_mid_outs", {vid_valid, vid_data, gl_ack, gl_rdata, clr_busy, clr_done,
                             ram_en, ram_we, ram_addr, ram_wdata}, 0);
        quiet_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (clr_done || clr_busy || ram_en) quiet_bad++;
        end
        chk("rst_no_done", quiet_bad, 0);
        @(negedge clk); clr_start = 1'b1;
        @(negedge clk); clr_start = 1'b0; #1;
        chk("restart_addr0", {clr_busy, ram_en, ram_we, ram_addr}, {1'b1, 1'b1, 1'b1, 8'd0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
